// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI slave front end and the single-port RAM:
// FSM state encoding, frame command codes and frame/counter width helpers.
package spi_ram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } spi_state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // A frame carries the two command bits on top of one address/data word.
    function automatic int frame_width(input int addr_size);
        return addr_size + 2;
    endfunction

    // The bit counter has to be able to hold the value FW itself, since it
    // parks there once a frame is complete.
    function automatic int count_width(input int addr_size);
        return $clog2(addr_size + 3);
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Serial-in/parallel-out receive register with a saturating bit counter, and
// a parallel-in/serial-out transmit register that drives the registered MISO
// bit. The final received bit is not stored here: the parent appends it to
// shift_data when it loads rx_data on the completing edge.
module spi_shift_reg
    import spi_ram_pkg::*;
#(
    parameter int ADDR_SIZE = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clear,
    input  logic                                shift_in,
    input  logic                                serial_in,
    input  logic                                load,
    input  logic [ADDR_SIZE-1:0]                parallel_in,
    input  logic                                shift_out,
    output logic [frame_width(ADDR_SIZE)-2:0]   shift_data,
    output logic [count_width(ADDR_SIZE)-1:0]   bit_cnt,
    output logic [count_width(ADDR_SIZE)-1:0]   tx_cnt,
    output logic                                serial_out
);

    localparam int FW    = frame_width(ADDR_SIZE);
    localparam int CNT_W = count_width(ADDR_SIZE);

    logic [ADDR_SIZE-2:0] tx_shift;

    // Receive path: shift MOSI in MSB first, counter stops at FW.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            shift_data <= '0;
            bit_cnt    <= '0;
        end else if (shift_in && bit_cnt != CNT_W'(FW)) begin
            shift_data <= {shift_data[FW-3:0], serial_in};
            bit_cnt    <= bit_cnt + CNT_W'(1);
        end
    end

    // Transmit path: MSB goes out on the load edge, the rest on following
    // shift edges; one shift past the last bit returns the line to 0.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            tx_shift   <= '0;
            tx_cnt     <= '0;
            serial_out <= 1'b0;
        end else if (load) begin
            tx_shift   <= parallel_in[ADDR_SIZE-2:0];
            tx_cnt     <= CNT_W'(1);
            serial_out <= parallel_in[ADDR_SIZE-1];
        end else if (shift_out) begin
            if (tx_cnt == CNT_W'(ADDR_SIZE)) begin
                serial_out <= 1'b0;
            end else begin
                serial_out <= tx_shift[ADDR_SIZE-2];
                tx_shift   <= {tx_shift[ADDR_SIZE-3:0], 1'b0};
                tx_cnt     <= tx_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave front end for the single-port RAM. SCK is clk; SS_n and MOSI are
// sampled on posedge clk. Frames are FW = ADDR_SIZE+2 bits, MSB first, after
// one selector bit. Read data from the RAM is returned MSB first on MISO.
// Optional build macro SPI_FRAME_CHECK_EN: checks frame command bits against
// the current state and flags mismatches on frame_err instead of rx_valid.
module spi_slave_fsm
    import spi_ram_pkg::*;
#(
    parameter int ADDR_SIZE = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   SS_n,
    input  logic                   MOSI,
    output logic                   MISO,
    output logic [ADDR_SIZE+1:0]   rx_data,
    output logic                   rx_valid,
    input  logic [ADDR_SIZE-1:0]   tx_data,
    input  logic                   tx_valid,
    output logic                   frame_err
);

    localparam int FW    = frame_width(ADDR_SIZE);
    localparam int CNT_W = count_width(ADDR_SIZE);

    spi_state_t       state;
    logic             rd_addr_done;
    logic             tx_busy;
    logic             tx_done;
    logic             rejected;

    logic [FW-2:0]    shift_data;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] tx_cnt;

    logic             shifting;
    logic             last_bit;
    logic             frame_full;
    logic             load_tx;
    logic             shift_tx;
    logic             cmd_ok;
    logic [FW-1:0]    frame_next;

    spi_shift_reg #(
        .ADDR_SIZE (ADDR_SIZE)
    ) u_shift (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (SS_n),
        .shift_in    (shifting),
        .serial_in   (MOSI),
        .load        (load_tx),
        .parallel_in (tx_data),
        .shift_out   (shift_tx),
        .shift_data  (shift_data),
        .bit_cnt     (bit_cnt),
        .tx_cnt      (tx_cnt),
        .serial_out  (MISO)
    );

    // Datapath decodes: frame completion, read-data wait window and command check.
    always_comb begin
        frame_next = {shift_data, MOSI};
        shifting   = !SS_n && (state == WRITE || state == READ_ADD || state == READ_DATA);
        last_bit   = shifting && (bit_cnt == CNT_W'(FW - 1));
        frame_full = (bit_cnt == CNT_W'(FW));
        load_tx    = !SS_n && (state == READ_DATA) && frame_full && !rejected
                     && !tx_busy && !tx_done && tx_valid;
        shift_tx   = !SS_n && tx_busy;
        cmd_ok     = 1'b1;
`ifdef SPI_FRAME_CHECK_EN
        case (state)
            WRITE:     cmd_ok = (frame_next[FW-1:FW-2] == CMD_WR_ADDR) ||
                                (frame_next[FW-1:FW-2] == CMD_WR_DATA);
            READ_ADD:  cmd_ok = (frame_next[FW-1:FW-2] == CMD_RD_ADDR);
            READ_DATA: cmd_ok = (frame_next[FW-1:FW-2] == CMD_RD_DATA);
            default:   cmd_ok = 1'b1;
        endcase
`endif
    end

`ifndef SPI_FRAME_CHECK_EN
    assign frame_err = 1'b0;
`endif

    // Control FSM: state sequencing, frame strobes and read-data handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_done <= 1'b0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
            rejected     <= 1'b0;
`ifdef SPI_FRAME_CHECK_EN
            frame_err    <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
`ifdef SPI_FRAME_CHECK_EN
            frame_err <= 1'b0;
`endif
            if (SS_n) begin
                state    <= IDLE;
                tx_busy  <= 1'b0;
                tx_done  <= 1'b0;
                rejected <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= CHK_CMD;
                    CHK_CMD: begin
                        if (!MOSI)
                            state <= WRITE;
                        else if (rd_addr_done)
                            state <= READ_DATA;
                        else
                            state <= READ_ADD;
                    end
                    default: state <= state;
                endcase

                if (last_bit) begin
                    if (cmd_ok) begin
                        rx_data  <= frame_next;
                        rx_valid <= 1'b1;
                        if (state == READ_ADD)
                            rd_addr_done <= 1'b1;
                    end else begin
                        rejected <= 1'b1;
`ifdef SPI_FRAME_CHECK_EN
                        frame_err <= 1'b1;
`endif
                    end
                end

                if (load_tx) begin
                    tx_busy <= 1'b1;
                end else if (tx_busy && tx_cnt == CNT_W'(ADDR_SIZE)) begin
                    tx_busy      <= 1'b0;
                    tx_done      <= 1'b1;
                    rd_addr_done <= 1'b0;
                end
            end
        end
    end

endmodule
